// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, reset PC default
// and the sequential PC increment.
package fetch_pkg;

   typedef logic [1:0] fetch_state_t;

   localparam fetch_state_t ST_IDLE = 2'd0;
   localparam fetch_state_t ST_REQ  = 2'd1;
   localparam fetch_state_t ST_WAIT = 2'd2;
   localparam fetch_state_t ST_HOLD = 2'd3;

   localparam logic [31:0] FETCH_RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] PC_INCR            = 32'd4;

   // Sequential successor of a PC; wraps modulo 2^32.
   function automatic logic [31:0] pc_inc(input logic [31:0] p);
      return p + PC_INCR;
   endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter flop with load enable. Optional word-alignment clamp and
// sticky misalignment flag, enabled by defining FETCH_ALIGN_CHECK_EN.
module pc_register
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = FETCH_RESET_PC_DEF
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] d,
   output logic [31:0] q,
   output logic        misalign_err
);

   logic [31:0] d_load;

`ifdef FETCH_ALIGN_CHECK_EN
   logic err_q;

   // Low bits are dropped so fetch always lands on a word boundary.
   assign d_load = {d[31:2], 2'b00};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (load && (d[1:0] != 2'b00)) begin
         err_q <= 1'b1;
      end
   end

   assign misalign_err = err_q;
`else
   assign d_load       = d;
   assign misalign_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= RESET_PC;
      end else if (load) begin
         q <= d_load;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage controller: owns the PC, runs the imem req/gnt/rvalid handshake
// and presents inst/inst_pc to decode. FETCH_ALIGN_CHECK_EN enables the PC alignment check.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | after reset; leaves on the first edge, ignores any response
// REQ     | imem_req high with imem_addr = pc, waiting for grant
// WAIT    | one fetch outstanding; drop set means its response is stale
// HOLD    | instruction valid toward decode until accepted or redirected
module pc_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = FETCH_RESET_PC_DEF
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] next_pc,
   input  logic        redirect,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        misalign_err
);

   fetch_state_t state;
   fetch_state_t state_nxt;
   logic         drop;
   logic         drop_nxt;
   logic         accept;
   logic         capture;
   logic         pc_load;
   logic         req_q;

   assign accept  = (state == ST_HOLD) && inst_valid && inst_ready;
   assign capture = (state == ST_WAIT) && imem_rvalid && !drop && !redirect;
   assign pc_load = (state != ST_IDLE) && (redirect || accept);

   pc_register #(
      .RESET_PC     (RESET_PC)
   ) u_pc_register (
      .clk          (clk),
      .reset        (reset),
      .load         (pc_load),
      .d            (next_pc),
      .q            (pc),
      .misalign_err (misalign_err)
   );

   assign pc_plus4  = pc_inc(pc);
   assign imem_addr = pc;
   assign imem_req  = req_q;

   always_comb begin
      state_nxt = state;
      drop_nxt  = drop;
      case (state)
         ST_IDLE: begin
            state_nxt = ST_REQ;
         end
         ST_REQ: begin
            // A grant coinciding with a redirect fetches the old pc; mark it stale.
            if (imem_gnt) begin
               state_nxt = ST_WAIT;
               drop_nxt  = redirect;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               drop_nxt  = 1'b0;
               state_nxt = capture ? ST_HOLD : ST_REQ;
            end else if (redirect) begin
               drop_nxt  = 1'b1;
            end
         end
         ST_HOLD: begin
            if (redirect || accept) begin
               state_nxt = ST_REQ;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            drop_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         drop  <= 1'b0;
         req_q <= 1'b0;
      end else begin
         state <= state_nxt;
         drop  <= drop_nxt;
         req_q <= (state_nxt == ST_REQ);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inst_valid <= 1'b0;
         inst       <= 32'h0;
         inst_pc    <= 32'h0;
      end else if (capture) begin
         inst_valid <= 1'b1;
         inst       <= imem_rdata;
         inst_pc    <= pc;
      end else if ((state == ST_HOLD) && (redirect || accept)) begin
         inst_valid <= 1'b0;
      end
   end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Fetch-stage controller sitting directly downstream of the 32-bit next-PC select multiplexer. It owns the program counter, fetches one instruction per PC from instruction memory over a request/grant/response handshake, and presents the instruction with its PC to decode through a valid/ready interface. It also returns `pc_plus4` to the multiplexer's sequential input. A one-cycle `redirect` loads a branch target and squashes any in-flight fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `next_pc` in 32: next-PC multiplexer output; sampled only on advance or redirect.
- `redirect` in 1: one-cycle pulse; `next_pc` is a branch target; same signal as the multiplexer select.
- `pc` out 32: current program counter.
- `pc_plus4` out 32: `pc + 4`, modulo 2^32; combinational.
- `imem_req` out 1 / `imem_addr` out 32: fetch request and word address.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1 / `imem_rdata` in 32: response, earliest one cycle after grant.
- `inst_valid` out 1 / `inst_ready` in 1 / `inst` out 32 / `inst_pc` out 32: decode-side handshake.
- `misalign_err` out 1: sticky misaligned-target flag (see Configuration).

## Operation
- Reset values: `pc`=`RESET_PC`, state IDLE, `imem_req`=0, `imem_addr`=`RESET_PC`, `inst_valid`=0, `inst`=0, `inst_pc`=0, `misalign_err`=0, drop flag 0.
- States:
  - IDLE: entered only by reset. Moves to REQ on the first clock edge after `reset` is deasserted. Any `imem_rvalid` is ignored.
  - REQ: `imem_req`=1 and `imem_addr`=`pc`. On `imem_gnt`, go to WAIT.
  - WAIT: `imem_req`=0. On `imem_rvalid` with the drop flag clear: capture `inst`←`imem_rdata` and `inst_pc`←`pc`, set `inst_valid`=1, go to HOLD. With the drop flag set: discard the response, clear drop, go to REQ.
  - HOLD: `inst`, `inst_pc` and `inst_valid` are held stable. On `inst_valid & inst_ready`: `pc`←`next_pc`, `inst_valid`←0, go to REQ.
- Redirect has priority over every other event in the same cycle; `pc`←`next_pc` in all non-IDLE states.
  - REQ with no grant: the new `pc` is requested next cycle; the address may change while ungranted.
  - REQ with a grant in the same cycle: the granted fetch is stale, so go to WAIT with drop=1.
  - WAIT with no `imem_rvalid`: set drop=1 and stay in WAIT.
  - WAIT with `imem_rvalid` in the same cycle: discard the response and go to REQ.
  - HOLD: squash with `inst_valid`←0, go to REQ. The instruction is not consumed even if `inst_ready`=1.
- Exactly one request is outstanding at a time. `pc` changes only on advance or redirect.
- Reset asserted mid-operation returns all outputs to reset values immediately. An outstanding memory response arriving later is ignored in IDLE.

## Timing
- `pc_plus4` and `imem_addr` are combinational from `pc`. Every other output is registered.
- Best case (grant in the first REQ cycle, `rvalid` one cycle later, `inst_ready`=1) is 3 cycles per instruction: REQ, WAIT, HOLD.
- Redirect in cycle t: `pc`=target at t+1. The first request for the target is visible at t+1 (from REQ or HOLD), or after the stale response drains (from WAIT).
- `inst_valid` rises the cycle after the accepted `imem_rvalid`.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - Whenever `pc` loads `next_pc` with `next_pc[1:0]`≠0, bits [1:0] are forced to 0 and `misalign_err` is set.
  - `misalign_err` stays set until reset.
- Undefined: `next_pc` is loaded unchanged and `misalign_err` is tied to 0. The port exists in both builds.

## Structure
- Shared package `fetch_pkg` holds:
  - the state typedef {IDLE, REQ, WAIT, HOLD},
  - `FETCH_RESET_PC_DEF` = 32'h0000_0000,
  - `PC_INCR` = 32'd4.
- One sub-module, `pc_register`: the PC flop with async reset, a load enable, the optional alignment clamp, and the sticky error flag. The FSM and handshake logic stay in `pc_fetch_unit`.

## Test plan
- Reset with `RESET_PC`=32'h0000_0040, `imem_gnt`=1, `rvalid` one cycle after grant, `inst_ready`=1 → `imem_addr` 0x40, then 0x44, then 0x48, one instruction every 3 cycles; `inst_pc` matches each address.
- `inst_ready`=0 for 5 cycles in HOLD with `inst`=32'hDEADBEEF → `inst` and `inst_valid` stable for all 5 cycles; `pc` advances only on the ready cycle.
- Redirect to 0x100 while in WAIT, then stale `rvalid` with data 0x11111111 → stale data never appears on `inst`; next `imem_addr`=0x100.
- Redirect to 0x200 in HOLD with `inst_ready`=1 in the same cycle → no handshake counted; `inst_valid`=0 next cycle; next request 0x200.
- `pc`=32'hFFFF_FFFC → `pc_plus4`=0; fetch wraps to address 0.
- With `FETCH_ALIGN_CHECK_EN`, redirect to 0x103 → `pc`=0x100 and `misalign_err`=1, held until reset. Without the macro → `pc`=0x103 and `misalign_err`=0.
